// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter driving one shared memory port, one transaction in flight.
// Write ack 2 cycles after the sample edge, read ack RD_LAT+2; the losing master stalls by holding req.
module mem_port_arbiter #(
  parameter int AW     = 64,
  parameter int DW     = 64,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [1:0]    grant,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       last_m1;
  logic       own_m1;
  logic       pick_m1;
  logic [2:0] cnt;

  // m1 wins when alone, or on a tie when m0 was served last
  always_comb pick_m1 = m1_req & (~m0_req | ~last_m1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_m1   <= 1'b1;
      own_m1    <= 1'b0;
      cnt       <= 3'd0;
      grant     <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            own_m1    <= pick_m1;
            grant     <= pick_m1 ? 2'b10 : 2'b01;
            mem_addr  <= pick_m1 ? m1_addr : m0_addr;
            mem_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            mem_we    <= pick_m1 ? m1_we : m0_we;
            mem_re    <= pick_m1 ? ~m1_we : ~m0_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_we still reflects the latched direction during ISSUE
          cnt   <= 3'd1;
          state <= mem_we ? RESP : WAIT;
        end
        WAIT: begin
          if (cnt == LAT) begin
            if (own_m1) m1_rdata <= mem_rdata;
            else        m0_rdata <= mem_rdata;
            cnt   <= 3'd0;
            state <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          m0_ack  <= ~own_m1;
          m1_ack  <= own_m1;
          last_m1 <= own_m1;
          grant   <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
